// File: rtl/mux9_rr_arbiter.sv
// Round-robin arbiter and sequencer for the shared 9-input source mux.
// Picks one requester fairly, holds the mux select while the consumer
// handshakes, pulses a per-source completion, and aborts stalled grants
// through a wait-cycle watchdog. Every output comes straight from a flop.
module mux9_rr_arbiter #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       clk_i,
   input  logic       reset_i,
   input  logic [8:0] req_i,
   input  logic       out_ready_i,
   output logic [3:0] sel_o,
   output logic [8:0] gnt_o,
   output logic       out_valid_o,
   output logic [8:0] done_o,
   output logic       timeout_err_o,
   output logic       busy_o
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t     state_q, state_d;
   logic [3:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [3:0] sel_q, sel_d;
   logic [8:0] gnt_q, gnt_d;
   logic       ovld_q, ovld_d;
   logic [8:0] done_q, done_d;
   logic       terr_q, terr_d;
   logic       busy_q, busy_d;

   logic       found;
   logic [3:0] win;
   logic [4:0] idx;
   logic [3:0] ptr_after;
   logic       to_hit;

   // Search order ptr, ptr+1, ... wrapping at 9; first asserted request wins.
   always_comb begin
      found = 1'b0;
      win   = '0;
      idx   = '0;
      for (int k = 0; k < 9; k++) begin
         idx = 5'(ptr_q) + 5'(k);
         if (idx >= 5'd9) idx = idx - 5'd9;
         if (!found && req_i[idx]) begin
            found = 1'b1;
            win   = idx[3:0];
         end
      end
   end

   // Pointer moves past the served source; watchdog compares the saturating wait count.
   always_comb begin
      ptr_after = (sel_q == 4'd8) ? 4'd0 : sel_q + 4'd1;
      to_hit    = (TIMEOUT != 0) && (cnt_q == 8'(TIMEOUT - 1));
   end

   // Next-state and registered-output logic for the IDLE/GRANT machine.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      gnt_d   = gnt_q;
      ovld_d  = ovld_q;
      busy_d  = busy_q;
      done_d  = '0;
      terr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            gnt_d  = '0;
            ovld_d = 1'b0;
            busy_d = 1'b0;
            cnt_d  = '0;
            if (found) begin
               state_d = GRANT;
               sel_d   = win;
               gnt_d   = 9'd1 << win;
               ovld_d  = 1'b1;
               busy_d  = 1'b1;
            end
         end
         GRANT: begin
            // Accept wins over timeout, which wins over withdraw.
            if (out_ready_i || to_hit || ((req_i & gnt_q) == '0)) begin
               state_d = IDLE;
               gnt_d   = '0;
               ovld_d  = 1'b0;
               busy_d  = 1'b0;
               cnt_d   = '0;
               if (out_ready_i) begin
                  done_d = gnt_q;
                  ptr_d  = ptr_after;
               end else if (to_hit) begin
                  terr_d = 1'b1;
                  ptr_d  = ptr_after;
               end
            end else if (cnt_q != 8'hFF) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         sel_q   <= '0;
         gnt_q   <= '0;
         ovld_q  <= 1'b0;
         done_q  <= '0;
         terr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         sel_q   <= sel_d;
         gnt_q   <= gnt_d;
         ovld_q  <= ovld_d;
         done_q  <= done_d;
         terr_q  <= terr_d;
         busy_q  <= busy_d;
      end
   end

   assign sel_o         = sel_q;
   assign gnt_o         = gnt_q;
   assign out_valid_o   = ovld_q;
   assign done_o        = done_q;
   assign timeout_err_o = terr_q;
   assign busy_o        = busy_q;

endmodule

// File: tb/tb_mux9_rr_arbiter.sv
// Bench for mux9_rr_arbiter: directed scenarios from the block's behaviour
// plus random traffic, compared against a transaction-level model.
module tb_mux9_rr_arbiter;

   localparam int TO = 4;

   logic       clk, reset;
   logic [8:0] req;
   logic       out_ready;
   logic [3:0] sel_o;
   logic [8:0] gnt_o, done_o;
   logic       out_valid_o, timeout_err_o, busy_o;

   int n_chk  = 0;
   int n_pass = 0;

   // Model: which source currently owns the mux (-1 when none), the
   // fairness pointer, and how many stalled cycles the owner has used.
   int         m_cur, m_ptr, m_wait;
   int         e_sel;
   logic [8:0] e_gnt, e_done;
   logic       e_ovld, e_terr, e_busy;

   mux9_rr_arbiter #(.TIMEOUT(TO)) dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .out_ready_i(out_ready),
      .sel_o(sel_o), .gnt_o(gnt_o), .out_valid_o(out_valid_o),
      .done_o(done_o), .timeout_err_o(timeout_err_o), .busy_o(busy_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [24:0] got_vec();
      return {sel_o, gnt_o, out_valid_o, done_o, timeout_err_o, busy_o};
   endfunction

   function automatic logic [24:0] exp_vec();
      return {4'(e_sel), e_gnt, e_ovld, e_done, e_terr, e_busy};
   endfunction

   task automatic model_reset();
      m_cur = -1; m_ptr = 0; m_wait = 0;
      e_sel = 0; e_gnt = '0; e_ovld = 0; e_done = '0; e_terr = 0; e_busy = 0;
   endtask

   task automatic model_release();
      m_cur = -1; m_wait = 0;
      e_gnt = '0; e_ovld = 0; e_busy = 0;
   endtask

   // One clock of the transfer protocol, written as transactions.
   task automatic model_step(input logic [8:0] r, input logic rdy);
      int s;
      e_done = '0;
      e_terr = 0;
      if (m_cur < 0) begin
         model_release();
         for (int k = 0; k < 9; k++) begin
            s = (m_ptr + k) % 9;
            if (m_cur < 0 && r[s]) begin
               m_cur = s; m_wait = 0;
               e_sel = s; e_gnt = 9'd1 << s; e_ovld = 1; e_busy = 1;
            end
         end
      end else if (rdy) begin
         e_done = 9'd1 << m_cur;
         m_ptr  = (m_cur + 1) % 9;
         model_release();
      end else if (TO != 0 && m_wait + 1 == TO) begin
         e_terr = 1;
         m_ptr  = (m_cur + 1) % 9;
         model_release();
      end else if (!r[m_cur]) begin
         model_release();
      end else begin
         m_wait++;
      end
   endtask

   // Drive inputs for one cycle, advance the model at the edge, land on the falling edge.
   task automatic step(input logic [8:0] r, input logic rdy);
      req = r; out_ready = rdy;
      @(posedge clk);
      model_step(r, rdy);
      @(negedge clk);
   endtask

   task automatic do_reset();
      req = '0; out_ready = 0;
      reset = 1;
      model_reset();
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_reset();
      reset = 1; req = '0; out_ready = 0;
      model_reset();
      @(negedge clk);
      n_chk++;
      if (got_vec() !== 25'd0) $display("FAIL reset_state got=%h exp=%h", got_vec(), 25'd0);
      else n_pass++;
      reset = 0;
   endtask

   task automatic test_single();
      do_reset();
      step(9'h004, 1);
      n_chk++;
      if ({sel_o, gnt_o, out_valid_o, busy_o} !== {4'd2, 9'h004, 1'b1, 1'b1})
         $display("FAIL single_grant got sel=%0d gnt=%h v=%b exp sel=2 gnt=004 v=1", sel_o, gnt_o, out_valid_o);
      else n_pass++;
      step(9'h00C, 1);
      n_chk++;
      if ({done_o, out_valid_o, gnt_o} !== {9'h004, 1'b0, 9'h000})
         $display("FAIL single_done got done=%h v=%b gnt=%h exp done=004 v=0 gnt=000", done_o, out_valid_o, gnt_o);
      else n_pass++;
      // Pointer now 3: with sources 2 and 3 both asking, 3 must win.
      step(9'h00C, 1);
      n_chk++;
      if (sel_o !== 4'd3) $display("FAIL single_ptr got sel=%0d exp 3", sel_o);
      else n_pass++;
      n_chk++;
      if (got_vec() !== exp_vec()) $display("FAIL single_model got=%h exp=%h", got_vec(), exp_vec());
      else n_pass++;
   endtask

   task automatic test_fairness();
      int cnt [9];
      int order_ok;
      int nxt;
      do_reset();
      foreach (cnt[i]) cnt[i] = 0;
      order_ok = 1; nxt = 0;
      for (int c = 0; c < 36; c++) begin
         step(9'h1FF, 1);
         n_chk++;
         if (got_vec() !== exp_vec()) $display("FAIL fair_cycle%0d got=%h exp=%h", c, got_vec(), exp_vec());
         else n_pass++;
         if (c % 2 == 0) begin
            if (sel_o !== 4'(nxt) || out_valid_o !== 1'b1) order_ok = 0;
            nxt = (nxt + 1) % 9;
         end
         for (int i = 0; i < 9; i++) if (done_o[i] === 1'b1) cnt[i]++;
      end
      n_chk++;
      if (order_ok != 1) $display("FAIL fair_order got out-of-order grant exp 0..8 rotation");
      else n_pass++;
      for (int i = 0; i < 9; i++) begin
         n_chk++;
         if (cnt[i] != 2) $display("FAIL fair_done%0d got=%0d exp=2", i, cnt[i]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(9'h080, 0);
      step(9'h080, 1);
      step(9'h101, 1);
      n_chk++;
      if (sel_o !== 4'd8 || gnt_o !== 9'h100) $display("FAIL wrap_first got sel=%0d gnt=%h exp sel=8 gnt=100", sel_o, gnt_o);
      else n_pass++;
      step(9'h101, 1);
      step(9'h101, 1);
      n_chk++;
      if (sel_o !== 4'd0 || gnt_o !== 9'h001) $display("FAIL wrap_second got sel=%0d gnt=%h exp sel=0 gnt=001", sel_o, gnt_o);
      else n_pass++;
      step(9'h000, 1);
   endtask

   task automatic test_timeout();
      int vcnt;
      do_reset();
      vcnt = 0;
      for (int c = 0; c < TO; c++) begin
         step(9'h010, 0);
         if (out_valid_o === 1'b1 && timeout_err_o === 1'b0) vcnt++;
      end
      n_chk++;
      if (vcnt != TO) $display("FAIL timeout_valid_cycles got=%0d exp=%0d", vcnt, TO);
      else n_pass++;
      step(9'h030, 0);
      n_chk++;
      if ({timeout_err_o, done_o, out_valid_o} !== {1'b1, 9'h000, 1'b0})
         $display("FAIL timeout_pulse got terr=%b done=%h v=%b exp terr=1 done=000 v=0", timeout_err_o, done_o, out_valid_o);
      else n_pass++;
      step(9'h030, 1);
      n_chk++;
      if (sel_o !== 4'd5) $display("FAIL timeout_ptr got sel=%0d exp 5", sel_o);
      else n_pass++;
      step(9'h000, 1);
   endtask

   task automatic test_withdraw();
      do_reset();
      step(9'h002, 0);
      step(9'h002, 1);          // ptr -> 2
      step(9'h008, 0);          // grant 3
      step(9'h000, 0);          // withdraw
      n_chk++;
      if ({done_o, out_valid_o, gnt_o, timeout_err_o} !== {9'h000, 1'b0, 9'h000, 1'b0})
         $display("FAIL withdraw_idle got done=%h v=%b gnt=%h exp done=000 v=0 gnt=000", done_o, out_valid_o, gnt_o);
      else n_pass++;
      step(9'h018, 0);          // ptr still 2 -> source 3 before 4
      n_chk++;
      if (sel_o !== 4'd3) $display("FAIL withdraw_ptr got sel=%0d exp 3", sel_o);
      else n_pass++;
      step(9'h000, 1);          // drop and ready together: accepted
      n_chk++;
      if (done_o !== 9'h008) $display("FAIL withdraw_accept got done=%h exp 008", done_o);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int bad;
      do_reset();
      step(9'h040, 0);
      #2 reset = 1;
      #1;
      n_chk++;
      if (got_vec() !== 25'd0) $display("FAIL reset_mid got=%h exp=%h", got_vec(), 25'd0);
      else n_pass++;
      model_reset();
      @(negedge clk);
      reset = 0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step(9'h000, 1);
         if (done_o !== 9'h000 || timeout_err_o !== 1'b0) bad++;
      end
      n_chk++;
      if (bad != 0) $display("FAIL reset_mid_pulse got=%0d stray pulses exp=0", bad);
      else n_pass++;
   endtask

   task automatic test_random();
      logic [8:0] r;
      logic       y;
      do_reset();
      r = '0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) r = 9'($urandom) & 9'($urandom);
         y = ($urandom_range(0, 4) == 0);
         step(r, y);
         n_chk++;
         if (got_vec() !== exp_vec()) $display("FAIL random_cycle%0d got=%h exp=%h", c, got_vec(), exp_vec());
         else n_pass++;
      end
   endtask

   initial begin
      reset = 1; req = '0; out_ready = 0;
      model_reset();
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_timeout();
      test_withdraw();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
